// File: rtl/iec_line_filter_pkg.sv
// Shared definitions for the IEC serial-bus input conditioner: channel map,
// idle level, per-sample event encoding and the counter-width helper.
package iec_pkg;

    localparam int IEC_DATA     = 0;
    localparam int IEC_CLK      = 1;
    localparam int IEC_ATN      = 2;
    localparam int IEC_CHANNELS = 3;

    // The bus idles high, so every line comes out of reset released.
    localparam logic [IEC_CHANNELS-1:0] IEC_IDLE = '1;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_RISE,
        EV_FALL,
        EV_GLITCH
    } iec_event_e;

    function automatic int cnt_width(input int stable);
        return (stable > 1) ? $clog2(stable) : 1;
    endfunction

endpackage

// File: rtl/iec_line_filter_if.sv
// Line-side bundle of the input conditioner; the filter is the slave, the
// drive logic (or a bench) is the master.
interface iec_line_filter_if
    import iec_pkg::*;
#(
    parameter int CHANNELS = IEC_CHANNELS,
    parameter int GCNT_W   = 16
) ();

    logic                sample_en;
    logic [CHANNELS-1:0] bypass;
    logic [CHANNELS-1:0] din;
    logic                glitch_clr;
    logic [CHANNELS-1:0] dout;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] glitch;
    logic [GCNT_W-1:0]   glitch_cnt;

    modport master (
        output sample_en, bypass, din, glitch_clr,
        input  dout, rise, fall, glitch, glitch_cnt
    );

    modport slave (
        input  sample_en, bypass, din, glitch_clr,
        output dout, rise, fall, glitch, glitch_cnt
    );

endinterface

// File: rtl/iec_line_filter_ch.sv
// One line: synchroniser chain, stability counter and registered
// rise/fall/glitch strobes.
module iec_line_filter_ch
    import iec_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   STABLE      = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_en_i,
    input  logic bypass_i,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o,
    output logic glitch_o
);

    localparam int            CW       = cnt_width(STABLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, fall_q, glitch_q;
    iec_event_e             ev_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        cnt_d  = cnt_q;
        dout_d = dout_q;
        ev_d   = EV_NONE;
        if (bypass_i) begin
            cnt_d = '0;
            if (sample_en_i && (synced != dout_q)) begin
                dout_d = synced;
                ev_d   = synced ? EV_RISE : EV_FALL;
            end
        end else if (sample_en_i) begin
            if (synced == dout_q) begin
                if (cnt_q != '0) begin
                    cnt_d = '0;
                    ev_d  = EV_GLITCH;
                end
            end else if (cnt_q == CNT_LAST) begin
                dout_d = synced;
                cnt_d  = '0;
                ev_d   = synced ? EV_RISE : EV_FALL;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the synchroniser is reset to the idle level too, so release never fabricates an edge.
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            cnt_q    <= '0;
            dout_q   <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its neighbour's pre-edge value.
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din_i};
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            rise_q   <= (ev_d == EV_RISE);
            fall_q   <= (ev_d == EV_FALL);
            glitch_q <= (ev_d == EV_GLITCH);
        end
    end

    assign dout_o   = dout_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign glitch_o = glitch_q;

endmodule

// File: rtl/iec_line_filter.sv
// Multi-channel IEC line conditioner: one filter per line plus a saturating
// total of aborted changes across all lines.
module iec_line_filter
    import iec_pkg::*;
#(
    parameter int                  CHANNELS    = IEC_CHANNELS,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  STABLE      = 2,
    parameter logic [CHANNELS-1:0] RESET_VAL   = IEC_IDLE,
    parameter int                  GCNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    iec_line_filter_if.slave   bus
);

    localparam int             PW      = $clog2(CHANNELS + 1);
    localparam int             SW      = GCNT_W + PW;
    localparam logic [SW-1:0]  CNT_MAX = SW'({GCNT_W{1'b1}});

    logic [CHANNELS-1:0] dout, rise, fall, glitch;
    logic [SW-1:0]       pop, sum;
    logic [GCNT_W-1:0]   glitch_cnt_q, glitch_cnt_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        iec_line_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE      (STABLE),
            .RESET_VAL   (RESET_VAL[i])
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .sample_en_i (bus.sample_en),
            .bypass_i    (bus.bypass[i]),
            .din_i       (bus.din[i]),
            .dout_o      (dout[i]),
            .rise_o      (rise[i]),
            .fall_o      (fall[i]),
            .glitch_o    (glitch[i])
        );
    end

    // A clear drops history but still counts the glitches visible this cycle.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pop = pop + SW'(glitch[i]);
        end
        sum          = bus.glitch_clr ? pop : (SW'(glitch_cnt_q) + pop);
        glitch_cnt_d = (sum > CNT_MAX) ? {GCNT_W{1'b1}} : sum[GCNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign bus.dout       = dout;
    assign bus.rise       = rise;
    assign bus.fall       = fall;
    assign bus.glitch     = glitch;
    assign bus.glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_iec_line_filter.sv
// Directed bench: default filter (a) and a STABLE=3, 3-bit-counter filter (b)
// for sample-enable gating and counter saturation.
module tb_iec_line_filter;
    import iec_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    iec_line_filter_if #(.CHANNELS(3), .GCNT_W(16)) bus_a ();
    iec_line_filter_if #(.CHANNELS(3), .GCNT_W(3))  bus_b ();

    iec_line_filter #(
        .CHANNELS(3), .SYNC_STAGES(2), .STABLE(2), .RESET_VAL(IEC_IDLE), .GCNT_W(16)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    iec_line_filter #(
        .CHANNELS(3), .SYNC_STAGES(2), .STABLE(3), .RESET_VAL(IEC_IDLE), .GCNT_W(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_a(input string tag, input logic [2:0] d, input logic [2:0] r,
                           input logic [2:0] f, input logic [2:0] g);
        check({tag, ".dout"},   bus_a.dout,   d);
        check({tag, ".rise"},   bus_a.rise,   r);
        check({tag, ".fall"},   bus_a.fall,   f);
        check({tag, ".glitch"}, bus_a.glitch, g);
    endtask

    // Low pulse of one clock on the masked lines of filter a.
    task automatic glitch_a(input string tag, input logic [2:0] mask,
                            input logic [15:0] exp_cnt, input logic clr);
        bus_a.din = IEC_IDLE & ~mask;
        tick();
        bus_a.din = IEC_IDLE;
        tick(2);
        check_a({tag, ".pre"}, 3'b111, 3'b000, 3'b000, 3'b000);
        tick();
        check_a({tag, ".hit"}, 3'b111, 3'b000, 3'b000, mask);
        bus_a.glitch_clr = clr;
        tick();
        bus_a.glitch_clr = 1'b0;
        check({tag, ".post_glitch"}, bus_a.glitch, 3'b000);
        check({tag, ".gcnt"}, bus_a.glitch_cnt, exp_cnt);
    endtask

    task automatic glitch_b(input string tag, input logic [2:0] mask, input logic [2:0] exp_cnt);
        bus_b.din = IEC_IDLE & ~mask;
        tick();
        bus_b.din = IEC_IDLE;
        tick(3);
        check({tag, ".hit"},  bus_b.glitch, mask);
        check({tag, ".dout"}, bus_b.dout,   3'b111);
        tick();
        check({tag, ".gcnt"}, bus_b.glitch_cnt, exp_cnt);
    endtask

    initial begin
        reset_n          = 1'b0;
        bus_a.sample_en  = 1'b1;
        bus_a.bypass     = 3'b000;
        bus_a.din        = IEC_IDLE;
        bus_a.glitch_clr = 1'b0;
        bus_b.sample_en  = 1'b1;
        bus_b.bypass     = 3'b000;
        bus_b.din        = IEC_IDLE;
        bus_b.glitch_clr = 1'b0;

        tick(3);
        check_a("reset", 3'b111, 3'b000, 3'b000, 3'b000);
        check("reset.gcnt", bus_a.glitch_cnt, 0);
        check("reset.b_dout", bus_b.dout, 3'b111);
        reset_n = 1'b1;
        tick(4);
        check_a("idle", 3'b111, 3'b000, 3'b000, 3'b000);

        // DATA falls: dout follows on the fourth edge after capture.
        bus_a.din = 3'b110;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_a($sformatf("fall0.k%0d", k), (k >= 4) ? 3'b110 : 3'b111,
                    3'b000, (k == 4) ? 3'b001 : 3'b000, 3'b000);
        end
        bus_a.din = 3'b111;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_a($sformatf("rise0.k%0d", k), (k >= 4) ? 3'b111 : 3'b110,
                    (k == 4) ? 3'b001 : 3'b000, 3'b000, 3'b000);
        end

        glitch_a("glitch_clk", 3'b010, 16'd1, 1'b0);
        glitch_a("glitch_all", 3'b111, 16'd4, 1'b0);
        glitch_a("glitch_clr", 3'b001, 16'd1, 1'b1);
        bus_a.glitch_clr = 1'b1;
        tick();
        bus_a.glitch_clr = 1'b0;
        check("clr_only.gcnt", bus_a.glitch_cnt, 0);

        // Bypass on ATN: one-clock pulse passes with three-clock latency.
        bus_a.bypass = 3'b100;
        tick(2);
        check_a("byp_on", 3'b111, 3'b000, 3'b000, 3'b000);
        bus_a.din = 3'b011;
        tick();
        bus_a.din = 3'b111;
        tick();
        check_a("byp.e2", 3'b111, 3'b000, 3'b000, 3'b000);
        tick();
        check_a("byp.e3", 3'b011, 3'b000, 3'b100, 3'b000);
        tick();
        check_a("byp.e4", 3'b111, 3'b100, 3'b000, 3'b000);
        tick();
        check_a("byp.e5", 3'b111, 3'b000, 3'b000, 3'b000);
        check("byp.gcnt", bus_a.glitch_cnt, 0);
        bus_a.bypass = 3'b000;
        tick(2);
        check_a("byp_off", 3'b111, 3'b000, 3'b000, 3'b000);

        // Asynchronous reset while a fall strobe is showing.
        bus_a.din = 3'b110;
        tick(4);
        check_a("pre_rst", 3'b110, 3'b000, 3'b001, 3'b000);
        reset_n = 1'b0;
        #1;
        check_a("async_rst", 3'b111, 3'b000, 3'b000, 3'b000);
        bus_a.din = 3'b111;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        check_a("post_rst", 3'b111, 3'b000, 3'b000, 3'b000);

        // Reset in the middle of a pending change discards it silently.
        bus_a.din = 3'b110;
        tick(3);
        reset_n   = 1'b0;
        bus_a.din = 3'b111;
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_a($sformatf("pend_rst.k%0d", k), 3'b111, 3'b000, 3'b000, 3'b000);
        end
        check("pend_rst.gcnt", bus_a.glitch_cnt, 0);

        // Filter b: one sample every 8 clocks, change needs three samples (c=3,11,19).
        bus_b.sample_en = 1'b0;
        bus_b.din       = 3'b110;
        for (int c = 0; c < 32; c++) begin
            bus_b.sample_en = ((c % 8) == 3);
            tick();
            check($sformatf("se.c%0d.dout", c), bus_b.dout, (c >= 19) ? 3'b110 : 3'b111);
            check($sformatf("se.c%0d.fall", c), bus_b.fall, (c == 19) ? 3'b001 : 3'b000);
            check($sformatf("se.c%0d.glitch", c), bus_b.glitch, 3'b000);
        end
        bus_b.sample_en = 1'b1;
        bus_b.din       = 3'b111;
        tick(6);
        check("se_back.dout", bus_b.dout, 3'b111);
        check("se_back.rise", bus_b.rise, 3'b000);

        glitch_b("sat1", 3'b111, 3'd3);
        glitch_b("sat2", 3'b111, 3'd6);
        glitch_b("sat3", 3'b111, 3'd7);
        glitch_b("sat4", 3'b001, 3'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iec_line_filter.md
# iec_line_filter

Parametrised multi-channel input conditioner for the drive-side serial bus (ATN/CLK/DATA and, optionally, parallel strobe lines). It generalises the fixed two-sample deglitcher in the drive logic with configurable synchroniser depth, stability length and channel count. It adds per-channel bypass, a sample-enable qualifier, rise/fall event strobes and a saturating glitch counter. It sits between the raw external bus inputs and the VIA port/CA1 inputs of each drive instance.

## Interface
- CHANNELS, 3: number of independent lines filtered.
- SYNC_STAGES, 2: metastability flops per channel; minimum 2.
- STABLE, 2: consecutive equal samples required before the output changes; minimum 1. STABLE=2 reproduces the legacy filter.
- RESET_VAL, all ones: per-channel output value during and after reset (bus idle is high).
- GCNT_W, 16: glitch counter width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sample_en  in  1  filter advances only on clocks where high; tie high for full-rate filtering.
- bypass  in  CHANNELS  per channel: 1 = skip stability filter (synchroniser still used).
- din  in  CHANNELS  raw asynchronous line inputs.
- dout  out  CHANNELS  filtered, registered line values.
- rise  out  CHANNELS  one-clock strobe, dout bit went 0->1 this clock.
- fall  out  CHANNELS  one-clock strobe, dout bit went 1->0 this clock.
- glitch  out  CHANNELS  one-clock strobe, a pending change on that channel was aborted.
- glitch_clr  in  1  synchronous clear of glitch_cnt.
- glitch_cnt  out  GCNT_W  saturating total of glitch events across all channels.

## Operation
- Synchroniser: SYNC_STAGES flops per channel, clocked every clk regardless of sample_en. The last stage is `synced`.
- Filter, per channel, counter cnt of width clog2(STABLE) (minimum 1 bit), evaluated only when sample_en=1:
  - If synced == dout and cnt != 0: cnt <= 0, glitch strobe.
  - If synced == dout and cnt == 0: no action.
  - If synced != dout and cnt == STABLE-1: dout <= synced, cnt <= 0, rise or fall strobe.
  - If synced != dout otherwise: cnt <= cnt+1.
- Bypass=1: dout <= synced on every sample_en clock; cnt forced to 0; rise/fall still generated; glitch never asserted. Toggling bypass clears cnt and does not itself produce a strobe.
- sample_en=0: cnt and dout hold; rise/fall/glitch are 0.
- Glitch counter:
  - Each clock, glitch_cnt <= min(glitch_cnt + popcount(glitch), 2^GCNT_W − 1).
  - If glitch_clr=1, glitch_cnt <= popcount(glitch) instead (clear wins over history, not over the current cycle's events).
- Reset (async assert, sync release through the flops' normal clocking):
  - All synchroniser stages <= RESET_VAL.
  - dout <= RESET_VAL; cnt <= 0.
  - rise/fall/glitch <= 0; glitch_cnt <= 0.
- Reset mid-pending-change discards the pending count; no strobe is emitted.

## Timing
- All outputs are registered; no combinational path from din or bypass to any output.
- Latency with sample_en=1 and bypass=0: a stable din change appears on dout SYNC_STAGES+STABLE clocks after the first capturing edge. Default parameters give 4 clocks.
- Bypass latency: SYNC_STAGES+1 clocks.
- rise/fall assert in the same clock dout changes, for exactly one clock.
- A pulse on din shorter than STABLE sample periods (after synchronisation) never reaches dout.
- glitch asserts on the sample where the line returns to dout.
- glitch_cnt reflects a glitch one clock after the glitch strobe.

## Structure
- Shared package iec_pkg holds:
  - Channel index constants: IEC_DATA=0, IEC_CLK=1, IEC_ATN=2.
  - IEC_CHANNELS=3.
  - IEC_IDLE (all ones), used as the RESET_VAL default.
- Sub-module iec_line_filter_ch: synchroniser + counter + strobes for one line, instantiated CHANNELS times via generate.
- The top level adds the popcount and saturating counter.

## Test plan
- Reset, din=3'b111 held: dout=3'b111; all strobes 0; glitch_cnt=0. Assert reset_n=0 mid-run: outputs return to these values immediately.
- din[0] 1->0 held, defaults: fall[0] pulses exactly at clock 4 after capture, dout[0]=0; no other channel strobes.
- din[1] low pulse of 1 clock, STABLE=2: dout unchanged; glitch[1] pulses once; glitch_cnt=1.
- All three channels glitch in the same sample: glitch_cnt +3 in one clock. With count at 0xFFFE, glitch_cnt saturates at 0xFFFF. glitch_clr with a simultaneous single glitch yields 1.
- sample_en pulsed every 8 clocks, STABLE=3: dout changes only after 3 qualifying samples; counter frozen between them.
- bypass[2]=1, din[2] 1-clock pulse: dout[2] follows with 3-clock latency; rise/fall both seen; glitch[2] stays 0.
